// File: rtl/dmem_pkg.sv
// Shared types and bus widths for the data-memory bus bridge.
// The optional watchdog is enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
package dmem_pkg;

   localparam int MEM_ADDR_BUS  = 32;
   localparam int MEM_DATA_BUS  = 32;
   localparam int MEM_WMASK_BUS = MEM_DATA_BUS / 8;

   // state | meaning
   // IDLE  | no access in flight; a new request is latched here
   // REQ   | bus_req asserted, waiting for bus_gnt
   // WAIT  | load granted, waiting for bus_rvalid
   // DONE  | stall released for one cycle; mem_rd holds the result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } dmem_state_t;

endpackage

// File: rtl/dmem_timeout_counter.sv
// Watchdog down-counter for dmem_bridge, built only with DMEM_BRIDGE_TIMEOUT_EN.
// Loaded on clear; expired flags the LIMIT-th enabled cycle after a clear.
module dmem_timeout_counter #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= LOAD_VAL;
      end else if (clear) begin
         r_cnt <= LOAD_VAL;
      end else if (enable && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign expired = enable && (r_cnt == '0);

endmodule

// File: rtl/dmem_bridge.sv
// Converts the single-cycle data memory port into a req/gnt/rvalid bus access,
// stalling the pipeline meanwhile. Watchdog abort enabled by DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int ADDR_W         = MEM_ADDR_BUS,
   parameter int DATA_W         = MEM_DATA_BUS,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic                mem_we,
   input  logic [ADDR_W-1:0]   mem_a,
   input  logic [DATA_W-1:0]   mem_wd,
   input  logic [DATA_W/8-1:0] mem_wmask,
   output logic [DATA_W-1:0]   mem_rd,
   output logic                stall,
   output logic                err,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wstrb,
   input  logic                bus_gnt,
   input  logic                bus_rvalid,
   input  logic [DATA_W-1:0]   bus_rdata
);

   dmem_state_t r_state, w_state_nxt;

   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_wstrb;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;

   logic w_capture;
   logic w_timeout;
   logic w_expired;
   logic w_cnt_clear;
   logic w_cnt_en;
   logic w_accept;

   assign w_accept    = (r_state == IDLE) && req_valid;
   assign w_cnt_clear = w_accept;
   assign w_cnt_en    = (r_state == REQ) || (r_state == WAIT);

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: if (req_valid) w_state_nxt = REQ;
         REQ: begin
            // A completed handshake wins over a watchdog hit in the same cycle.
            if (bus_gnt && (r_we || bus_rvalid)) begin
               w_state_nxt = DONE;
               w_capture   = !r_we;
            end else if (w_expired) begin
               w_state_nxt = DONE;
               w_timeout   = 1'b1;
            end else if (bus_gnt) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (bus_rvalid) begin
               w_state_nxt = DONE;
               w_capture   = 1'b1;
            end else if (w_expired) begin
               w_state_nxt = DONE;
               w_timeout   = 1'b1;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if (w_accept) begin
         r_we    <= mem_we;
         r_addr  <= {mem_a[ADDR_W-1:2], 2'b00};
         r_wdata <= mem_wd;
         r_wstrb <= mem_wmask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (w_capture) begin
            r_rdata <= bus_rdata;
         end else if (w_timeout) begin
            r_rdata <= '0;
         end
      end
   end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
   dmem_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_cnt_clear),
      .enable  (w_cnt_en),
      .expired (w_expired)
   );
   assign err = r_err;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_cnt;
   assign unused_cnt = w_cnt_clear ^ w_cnt_en ^ r_err;
   assign w_expired  = 1'b0;
   assign err        = 1'b0;
`endif

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^mem_a[1:0];

   // Gated with rst_n so a held req_valid cannot keep the pipeline frozen during reset.
   assign stall     = rst_n && ((r_state == IDLE) ? req_valid : (r_state != DONE));
   assign bus_req   = (r_state == REQ);
   assign bus_we    = r_we;
   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign bus_wstrb = r_wstrb;
   assign mem_rd    = r_rdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed, table-driven bench for dmem_bridge; the watchdog section follows
// whether DMEM_BRIDGE_TIMEOUT_EN is defined for the build.
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rd;
   logic        stall;
   logic        err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   int checks   = 0;
   int failures = 0;

   dmem_bridge #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_wmask  (mem_wmask),
      .mem_rd     (mem_rd),
      .stall      (stall),
      .err        (err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wstrb  (bus_wstrb),
      .bus_gnt    (bus_gnt),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "bench watchdog expired");
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  mask;
      logic [31:0] rdata;
      int          gnt_at;
      int          rv_at;
      logic [31:0] exp_addr;
      int          exp_stall;
      int          exp_req;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Cycle n=0 is the IDLE cycle carrying req_valid; gnt/rvalid are given as cycle indices.
   task automatic run_access(input vec_t v, input bit trail);
      int stalls = 0;
      int reqs   = 0;
      bit done   = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         req_valid  = 1'b1;
         mem_we     = v.we;
         mem_a      = v.addr;
         mem_wd     = v.wd;
         mem_wmask  = v.mask;
         bus_gnt    = (n == v.gnt_at);
         bus_rvalid = !v.we && (n == v.rv_at);
         bus_rdata  = bus_rvalid ? v.rdata : 32'hBAD0_BAD0;
         #1;
         if (n == 0) chk("idle_bus_req", {31'd0, bus_req}, 32'd0);
         if (bus_req) begin
            reqs++;
            chk("bus_addr",  bus_addr, v.exp_addr);
            chk("bus_we",    {31'd0, bus_we}, {31'd0, v.we});
            chk("bus_wdata", bus_wdata, v.wd);
            chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, v.mask});
         end
         if (stall) begin
            stalls++;
         end else begin
            done = 1'b1;
            chk("done_mem_rd", mem_rd, v.exp_rd);
            chk("done_err", {31'd0, err}, 32'd0);
         end
      end
      chk("stall_cycles", stalls, v.exp_stall);
      chk("req_cycles", reqs, v.exp_req);
      chk("completed", {31'd0, done}, 32'd1);
      if (trail) begin
         @(negedge clk);
         req_valid  = 1'b0;
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b0;
         #1;
         chk("trail_stall", {31'd0, stall}, 32'd0);
         chk("trail_bus_req", {31'd0, bus_req}, 32'd0);
         chk("trail_mem_rd", mem_rd, v.exp_rd);
      end
   endtask

   vec_t vecs[5];
   vec_t va, vb, vc;
   int   stalls;
   bit   done;

   initial begin
      //             we    addr          wd            mask     rdata        gnt rv  exp_addr      stall req exp_rd
      vecs[0] = '{1'b0, 32'h0000_1006, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 1, 1, 32'h0000_1004, 2, 1, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h2000_0013, 32'h1234_5678, 4'b0011, 32'h0000_0000, 3, 0, 32'h2000_0010, 4, 3, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 32'h0000_0FFF, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 1, 6, 32'h0000_0FFC, 7, 1, 32'hCAFE_F00D};
      vecs[3] = '{1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 4'b0000, 32'h0000_0000, 1, 0, 32'h0000_0044, 2, 1, 32'hCAFE_F00D};
      vecs[4] = '{1'b0, 32'hFFFF_FFFE, 32'h0F0F_0F0F, 4'b1010, 32'h0000_0001, 2, 4, 32'hFFFF_FFFC, 5, 2, 32'h0000_0001};

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      mem_we     = 1'b0;
      mem_a      = '0;
      mem_wd     = '0;
      mem_wmask  = '0;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_stall",     {31'd0, stall}, 32'd0);
      chk("rst_err",       {31'd0, err}, 32'd0);
      chk("rst_bus_req",   {31'd0, bus_req}, 32'd0);
      chk("rst_bus_addr",  bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_mem_rd",    mem_rd, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_access(vecs[i], 1'b1);

      // Back-to-back loads: second request seen in the IDLE cycle right after DONE.
      va = '{1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'h1111_1111, 1, 1, 32'h0000_0100, 2, 1, 32'h1111_1111};
      vb = '{1'b0, 32'h0000_0207, 32'h0, 4'hF, 32'h2222_2222, 1, 1, 32'h0000_0204, 2, 1, 32'h2222_2222};
      run_access(va, 1'b0);
      run_access(vb, 1'b1);

      // Reset during WAIT, then a stray response for the abandoned load.
      @(negedge clk);
      req_valid = 1'b1; mem_we = 1'b0; mem_a = 32'h0000_0300; mem_wd = 32'h0000_0077; mem_wmask = 4'hF;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      @(negedge clk);
      bus_gnt = 1'b1;
      #1;
      chk("rw_req_bus_req", {31'd0, bus_req}, 32'd1);
      @(negedge clk);
      bus_gnt = 1'b0;
      #1;
      chk("rw_wait_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rw_wait_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rw_stall",     {31'd0, stall}, 32'd0);
      chk("rw_bus_req",   {31'd0, bus_req}, 32'd0);
      chk("rw_err",       {31'd0, err}, 32'd0);
      chk("rw_bus_addr",  bus_addr, 32'd0);
      chk("rw_bus_wdata", bus_wdata, 32'd0);
      chk("rw_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
      chk("rw_mem_rd",    mem_rd, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; req_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
      #1;
      chk("stray_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      chk("stray_mem_rd",  mem_rd, 32'd0);
      chk("stray_bus_req", {31'd0, bus_req}, 32'd0);

      vc = '{1'b0, 32'h0000_0500, 32'h0, 4'hF, 32'h1357_2468, 1, 2, 32'h0000_0500, 3, 1, 32'h1357_2468};
      run_access(vc, 1'b1);

      // Grant never arrives.
      stalls = 0;
      done   = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         req_valid = 1'b1; mem_we = 1'b0; mem_a = 32'h0000_0400; bus_gnt = 1'b0; bus_rvalid = 1'b0;
         #1;
         if (stall) stalls++;
         else begin
            done = 1'b1;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            chk("to_err", {31'd0, err}, 32'd1);
            chk("to_mem_rd", mem_rd, 32'd0);
`endif
         end
      end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      chk("to_stall_cycles", stalls, 5);
      chk("to_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h9999_9999;
      #1;
      chk("to_err_pulse", {31'd0, err}, 32'd0);
      chk("to_idle_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      chk("to_late_rvalid", mem_rd, 32'd0);
`else
      chk("nogt_stall_cycles", stalls, 20);
      chk("nogt_stall", {31'd0, stall}, 32'd1);
      chk("nogt_bus_req", {31'd0, bus_req}, 32'd1);
      chk("nogt_err", {31'd0, err}, 32'd0);
      chk("nogt_mem_rd", mem_rd, 32'h1357_2468);
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("nogt_rst_bus_req", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Multi-cycle bus bridge directly downstream of the data memory stage. It accepts the stage's single-cycle data memory interface (address, write enable, write data, byte mask, read data) and converts each access into a request/grant/response transaction on the external data bus. While an access is in flight it stalls the pipeline, and it presents read data to the stage in the cycle the stall is released.

## Interface
Parameters:
- ADDR_W, 32, address width (matches `MEM_ADDR_BUS`)
- DATA_W, 32, data width (matches `MEM_DATA_BUS`)
- TIMEOUT_CYCLES, 255, watchdog limit; used only with DMEM_BRIDGE_TIMEOUT_EN

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  stage holds a load or store this cycle
- mem_we  in  1  1 = store, 0 = load
- mem_a  in  ADDR_W  byte address from the stage
- mem_wd  in  DATA_W  store data
- mem_wmask  in  DATA_W/8  byte-lane write mask
- mem_rd  out  DATA_W  read data to the stage
- stall  out  1  freeze the pipeline
- err  out  1  one-cycle pulse when an access was aborted by timeout
- bus_req  out  1  request valid on the bus
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word-aligned address
- bus_wdata  out  DATA_W  write data
- bus_wstrb  out  DATA_W/8  write byte strobes
- bus_gnt  in  1  bus accepted the request
- bus_rvalid  in  1  read response valid
- bus_rdata  in  DATA_W  read response data

## Operation
FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - stall = req_valid.
  - If req_valid: latch mem_we, {mem_a[ADDR_W-1:2], 2'b00}, mem_wd and mem_wmask into request registers, then go to REQ.
  - bus_rvalid arriving in IDLE is discarded.
- **REQ**
  - bus_req = 1; bus_* outputs are driven from the request registers and held stable until bus_gnt.
  - stall = 1.
  - gnt with store: go to DONE.
  - gnt with load and rvalid in the same cycle: capture rdata, go to DONE.
  - gnt with load and no rvalid: go to WAIT.
- **WAIT**
  - stall = 1; bus_req = 0.
  - On bus_rvalid: capture bus_rdata into rdata_q, go to DONE.
- **DONE**
  - stall = 0; mem_rd = rdata_q. The pipeline advances at the end of this cycle.
  - Always go to IDLE next cycle. req_valid in DONE belongs to the finishing instruction and is ignored.
- mem_rd = rdata_q in every state. rdata_q is unchanged by stores.
- The bridge performs no lane selection or extension. It always returns the full word; the stage extracts bytes and halfwords.
- A store with mem_wmask = 0 is still issued on the bus, with bus_wstrb = 0.

## Timing
- Reset values: state = IDLE, stall = 0, err = 0, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, bus_wstrb = 0, rdata_q = 0 (so mem_rd = 0).
- Minimum access costs 2 stall cycles:
  - cycle 0: IDLE with req_valid
  - cycle 1: REQ with gnt (plus rvalid for a load)
  - cycle 2: DONE, stall = 0
- Each cycle without gnt, and each cycle in WAIT, adds one stall cycle.
- Back-to-back accesses: the next access is seen in the IDLE cycle after DONE, giving one DONE/IDLE gap between bus requests.
- Reset mid-operation:
  - Asserting rst_n = 0 drops bus_req and stall immediately (asynchronously).
  - Any response for the abandoned transaction arrives in IDLE and is discarded.
- stall is a Moore output of state plus req_valid. It has no combinational path from any bus_* input.

## Configuration
- DMEM_BRIDGE_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter counts cycles spent in REQ and WAIT, and is cleared on entering REQ.
  - When the count reaches TIMEOUT_CYCLES, go to DONE with rdata_q = 0 and assert err for the DONE cycle.
  - A late rvalid then arrives in IDLE and is discarded.
- DMEM_BRIDGE_TIMEOUT_EN not defined:
  - No counter is built; err is tied to 0.
  - REQ and WAIT wait indefinitely.

## Structure
- The state enum dmem_state_t (IDLE, REQ, WAIT, DONE) goes in a shared package, dmem_pkg.
- Bus widths reuse `MEM_ADDR_BUS`, `MEM_DATA_BUS` and `MEM_WMASK_BUS` from the common defines.
- One sub-module, dmem_timeout_counter (clear, enable, expired), instantiated only under the macro.

## Test plan
- Load, mem_a = 0x0000_1006, gnt and rvalid both in cycle 1 with rdata 0xDEAD_BEEF:
  - bus_addr = 0x0000_1004
  - stall = 1 for 2 cycles
  - mem_rd = 0xDEAD_BEEF in the DONE cycle
- Store, mem_wd = 0x1234_5678, mask 4'b0011, gnt delayed 3 cycles:
  - bus fields held stable throughout, bus_wstrb = 4'b0011
  - stall = 1 for 4 cycles
  - mem_rd unchanged
- Load, gnt in cycle 1, rvalid 5 cycles later:
  - bus_req drops after gnt
  - stall released exactly one cycle after rvalid
- rst_n pulsed low during WAIT, then a stray rvalid arrives:
  - state = IDLE, all outputs at reset values
  - the stray response does not change mem_rd
- With the macro and TIMEOUT_CYCLES = 4, gnt never asserted:
  - DONE after 4 cycles in REQ
  - err = 1 for one cycle, mem_rd = 0
- Two loads back-to-back with zero bus wait:
  - second bus_req asserts 2 cycles after the first DONE
  - each load returns its own data
